// File: rtl/prog_mem_loader.sv
`timescale 1ns/1ps
// prog_mem_loader: run-time loadable program memory.
// A byte-serial load port fills the memory little-endian, one word at a time.
// A fetch port returns one instruction per request, exactly one cycle later,
// and flags misaligned, out-of-range or not-yet-loaded fetches.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   load_en             level, requests LOAD mode
//   load_valid/load_byte  one program byte per valid cycle
//   load_done           high while in RUN
//   load_overflow       sticky, a byte was dropped because memory was full
//   word_count          words written since the last load start
//   fetch_req/fetch_addr  fetch request and byte address
//   fetch_valid/fetch_instr/fetch_fault  registered fetch response
module prog_mem_loader #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 4,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic              load_valid,
    input  logic [7:0]        load_byte,
    output logic              load_done,
    output logic              load_overflow,
    output logic [ADDR_W:0]   word_count,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              fetch_fault
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);
    // Byte lane index needs at least one bit even for 8-bit words.
    localparam int unsigned IDX_W = (OFF_W == 0) ? 1 : OFF_W;
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(BYTES - 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT  = CNT_W'(DEPTH);
    localparam logic [31:0]       ALIGN_MASK = 32'(BYTES - 1);
    localparam logic [DATA_W-1:0] NOP_EXT    = DATA_W'(NOP_WORD);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic               load_entry_s;
    logic [IDX_W-1:0]   byte_idx_r;
    logic [CNT_W-1:0]   wr_ptr_r;
    logic [CNT_W-1:0]   word_count_r;
    logic [DATA_W-1:0]  asm_r;
    logic               load_overflow_r;
    logic               load_done_r;
    logic               fetch_valid_r;
    logic               fetch_fault_r;
    logic [DATA_W-1:0]  fetch_instr_r;
    logic [DATA_W-1:0]  mem_r [DEPTH];

    logic               full_s;
    logic               take_byte_s;
    logic               last_lane_s;
    logic [DATA_W-1:0]  merged_s;
    logic               mem_we_s;
    logic [DATA_W-1:0]  mem_wdata_s;
    logic [31:0]        word_idx_s;
    logic               misaligned_s;
    logic               out_of_range_s;
    logic               fetch_fault_s;

    assign load_done     = load_done_r;
    assign load_overflow = load_overflow_r;
    assign word_count    = word_count_r;
    assign fetch_valid   = fetch_valid_r;
    assign fetch_fault   = fetch_fault_r;
    assign fetch_instr   = fetch_instr_r;

    // Next-state logic; load_entry_s marks every transition into LOAD.
    always_comb begin
        next_state_s = state_r;
        load_entry_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (load_en) begin
                    next_state_s = ST_LOAD;
                    load_entry_s = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (!load_en) begin
                    next_state_s = ST_FLUSH;
                end else begin
                    next_state_s = ST_LOAD;
                end
            end
            ST_FLUSH: begin
                next_state_s = ST_RUN;
            end
            ST_RUN: begin
                if (load_en) begin
                    next_state_s = ST_LOAD;
                    load_entry_s = 1'b1;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Byte assembly and memory write decision.
    always_comb begin
        full_s      = (word_count_r == DEPTH_CNT);
        // A byte arriving as load_en falls is ignored: load_en gates capture.
        take_byte_s = (state_r == ST_LOAD) && load_en && load_valid;
        last_lane_s = (byte_idx_r == LAST_IDX);
        merged_s    = asm_r | (DATA_W'(load_byte) << {byte_idx_r, 3'b000});
        mem_we_s    = 1'b0;
        mem_wdata_s = {DATA_W{1'b0}};
        if (wr_ptr_r[ADDR_W]) begin
            // Pointer past the last word: never write out of range.
            mem_we_s = 1'b0;
        end else if (take_byte_s && !full_s && last_lane_s) begin
            mem_we_s    = 1'b1;
            mem_wdata_s = merged_s;
        end else if ((state_r == ST_FLUSH) && (byte_idx_r != {IDX_W{1'b0}}) && !full_s) begin
            // Unfilled upper lanes are already zero in asm_r.
            mem_we_s    = 1'b1;
            mem_wdata_s = asm_r;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Fetch fault classification against the state at the request edge.
    always_comb begin
        word_idx_s     = fetch_addr >> OFF_W;
        misaligned_s   = ((fetch_addr & ALIGN_MASK) != 32'h0000_0000);
        // Full 32-bit compare so high address bits also count as out of range.
        out_of_range_s = (word_idx_s >= 32'(word_count_r));
        fetch_fault_s  = misaligned_s || out_of_range_s || (state_r != ST_RUN);
    end

    // State register and load bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            load_done_r     <= 1'b0;
            byte_idx_r      <= {IDX_W{1'b0}};
            wr_ptr_r        <= {CNT_W{1'b0}};
            word_count_r    <= {CNT_W{1'b0}};
            asm_r           <= {DATA_W{1'b0}};
            load_overflow_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            load_done_r <= (next_state_s == ST_RUN);
            if (load_entry_s) begin
                byte_idx_r      <= {IDX_W{1'b0}};
                wr_ptr_r        <= {CNT_W{1'b0}};
                word_count_r    <= {CNT_W{1'b0}};
                asm_r           <= {DATA_W{1'b0}};
                load_overflow_r <= 1'b0;
            end else if (take_byte_s) begin
                if (full_s) begin
                    load_overflow_r <= 1'b1;
                end else if (last_lane_s) begin
                    wr_ptr_r     <= wr_ptr_r + CNT_W'(1);
                    word_count_r <= word_count_r + CNT_W'(1);
                    byte_idx_r   <= {IDX_W{1'b0}};
                    asm_r        <= {DATA_W{1'b0}};
                end else begin
                    asm_r      <= merged_s;
                    byte_idx_r <= byte_idx_r + IDX_W'(1);
                end
            end else if (state_r == ST_FLUSH) begin
                if ((byte_idx_r != {IDX_W{1'b0}}) && !full_s) begin
                    wr_ptr_r     <= wr_ptr_r + CNT_W'(1);
                    word_count_r <= word_count_r + CNT_W'(1);
                end
                byte_idx_r <= {IDX_W{1'b0}};
                asm_r      <= {DATA_W{1'b0}};
            end
        end
    end

    // Program memory write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[wr_ptr_r[ADDR_W-1:0]] <= mem_wdata_s;
        end
    end

    // Registered fetch response; instr holds when there is no request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_valid_r <= 1'b0;
            fetch_fault_r <= 1'b0;
            fetch_instr_r <= {DATA_W{1'b0}};
        end else if (fetch_req) begin
            fetch_valid_r <= 1'b1;
            if (fetch_fault_s) begin
                fetch_fault_r <= 1'b1;
                fetch_instr_r <= NOP_EXT;
            end else begin
                fetch_fault_r <= 1'b0;
                fetch_instr_r <= mem_r[word_idx_s[ADDR_W-1:0]];
            end
        end else begin
            fetch_valid_r <= 1'b0;
            fetch_fault_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prog_mem_loader.sv
`timescale 1ns/1ps
// Self-checking bench for prog_mem_loader (default 32-bit x 16-word config).
// A word-level model (list of loaded bytes -> words, count, run flag) predicts
// every fetch response; directed tests add literal expectations.
module tb_prog_mem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_en = 1'b0;
    logic        load_valid = 1'b0;
    logic [7:0]  load_byte = 8'h00;
    logic        load_done;
    logic        load_overflow;
    logic [4:0]  word_count;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = 32'h0;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        fetch_fault;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Model of the DUT as seen between clock edges.
    logic [31:0] model_mem [16];
    int          model_count = 0;
    bit          model_run = 1'b0;
    bit          model_ovf = 1'b0;

    logic [7:0]  bq[$];

    prog_mem_loader dut (
        .clk(clk), .rst(rst),
        .load_en(load_en), .load_valid(load_valid), .load_byte(load_byte),
        .load_done(load_done), .load_overflow(load_overflow), .word_count(word_count),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of the fetch port against the model.
    logic [31:0] last_instr = 32'h0;
    logic        cmp_ev;
    logic        cmp_ef;
    logic [31:0] cmp_ei;
    logic [31:0] cmp_idx;
    always @(posedge clk) begin
        if (rst) begin
            cmp_ev = 1'b0; cmp_ef = 1'b0; cmp_ei = 32'h0; last_instr = 32'h0;
        end else if (fetch_req) begin
            cmp_idx = fetch_addr >> 2;
            cmp_ev  = 1'b1;
            cmp_ef  = (fetch_addr[1:0] != 2'b00) || (cmp_idx >= 32'(model_count)) || !model_run;
            cmp_ei  = cmp_ef ? 32'h0 : model_mem[cmp_idx[3:0]];
            last_instr = cmp_ei;
        end else begin
            cmp_ev = 1'b0; cmp_ef = 1'b0; cmp_ei = last_instr;
        end
        #1;
        check("cmp_valid", 64'(fetch_valid), 64'(cmp_ev));
        check("cmp_fault", 64'(fetch_fault), 64'(cmp_ef));
        check("cmp_instr", 64'(fetch_instr), 64'(cmp_ei));
    end

    // Full load cycle: enter LOAD, stream bytes, drop load_en, reach RUN.
    // fae issues a fetch of 0x0 together with load_en (RUN->LOAD overlap).
    task automatic do_load(input logic [7:0] q[$], input bit fae, input logic [31:0] fae_instr);
        int n;
        logic [31:0] w;
        n = q.size();
        load_en = 1'b1;
        load_valid = 1'b0;
        if (fae) begin
            fetch_req = 1'b1;
            fetch_addr = 32'h0;
        end
        @(negedge clk);
        model_run = 1'b0;
        model_count = 0;
        if (fae) begin
            check("entry_fetch_fault", 64'(fetch_fault), 64'd0);
            check("entry_fetch_instr", 64'(fetch_instr), 64'(fae_instr));
        end
        check("entry_word_count", 64'(word_count), 64'd0);
        check("entry_overflow", 64'(load_overflow), 64'd0);
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_byte = q[i];
            @(negedge clk);
            if (i == 0 && fae) begin
                check("after_entry_fault", 64'(fetch_fault), 64'd1);
            end
            fetch_req = 1'b0;
        end
        // Byte presented as load_en falls must be ignored.
        load_en = 1'b0;
        load_valid = 1'b1;
        load_byte = 8'hFF;
        @(negedge clk);
        load_valid = 1'b0;
        check("flush_not_done", 64'(load_done), 64'd0);
        @(negedge clk);
        model_count = (n + 3) / 4;
        if (model_count > 16) model_count = 16;
        model_ovf = (n > 64);
        for (int wi = 0; wi < model_count; wi++) begin
            w = 32'h0;
            for (int b = 0; b < 4; b++) begin
                if (4 * wi + b < n) w[8*b +: 8] = q[4 * wi + b];
            end
            model_mem[wi] = w;
        end
        model_run = 1'b1;
        check("run_done", 64'(load_done), 64'd1);
        check("run_word_count", 64'(word_count), 64'(model_count));
        check("run_overflow", 64'(load_overflow), 64'(model_ovf));
    endtask

    task automatic fetch_lit(input string name, input logic [31:0] a,
                             input logic [31:0] ei, input logic ef);
        fetch_req = 1'b1;
        fetch_addr = a;
        @(negedge clk);
        fetch_req = 1'b0;
        check({name, "_valid"}, 64'(fetch_valid), 64'd1);
        check({name, "_fault"}, 64'(fetch_fault), 64'(ef));
        check({name, "_instr"}, 64'(fetch_instr), 64'(ei));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_done", 64'(load_done), 64'd0);
        check("rst_ovf", 64'(load_overflow), 64'd0);
        check("rst_wc", 64'(word_count), 64'd0);
        check("rst_valid", 64'(fetch_valid), 64'd0);
        check("rst_fault", 64'(fetch_fault), 64'd0);
        check("rst_instr", 64'(fetch_instr), 64'd0);

        // Fetch while IDLE faults.
        fetch_lit("idle", 32'h0, 32'h0, 1'b1);

        // Two words, back-to-back fetches.
        bq = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        do_load(bq, 1'b0, 32'h0);
        check("t1_wc_lit", 64'(word_count), 64'd2);
        fetch_req = 1'b1;
        fetch_addr = 32'h0;
        @(negedge clk);
        fetch_addr = 32'h4;
        check("b2b0_instr", 64'(fetch_instr), 64'h1);
        check("b2b0_fault", 64'(fetch_fault), 64'd0);
        @(negedge clk);
        fetch_req = 1'b0;
        check("b2b1_instr", 64'(fetch_instr), 64'h2);
        check("b2b1_valid", 64'(fetch_valid), 64'd1);
        @(negedge clk);
        check("idle_valid", 64'(fetch_valid), 64'd0);
        check("hold_instr", 64'(fetch_instr), 64'h2);

        // Faulting fetches after the 2-word load.
        fetch_lit("oor", 32'h8, 32'h0, 1'b1);
        fetch_lit("misal", 32'h2, 32'h0, 1'b1);
        fetch_lit("high", 32'h1000, 32'h0, 1'b1);

        // Partial last word.
        bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        do_load(bq, 1'b0, 32'h0);
        check("t2_wc_lit", 64'(word_count), 64'd2);
        fetch_lit("partial", 32'h4, 32'h0000_00EE, 1'b0);
        fetch_lit("full0", 32'h0, 32'hDDCC_BBAA, 1'b0);

        // Overflow: 68 bytes into 16 words.
        bq.delete();
        for (int i = 0; i < 68; i++) bq.push_back(8'(i));
        do_load(bq, 1'b0, 32'h0);
        check("ovf_wc_lit", 64'(word_count), 64'd16);
        check("ovf_flag_lit", 64'(load_overflow), 64'd1);
        fetch_lit("ovf_oor", 32'h40, 32'h0, 1'b1);
        fetch_lit("w15", 32'h3C, 32'h3F3E_3D3C, 1'b0);

        // Asynchronous reset mid-load, then a clean reload.
        load_en = 1'b1;
        @(negedge clk);
        model_run = 1'b0;
        model_count = 0;
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_byte = 8'h90 + 8'(i);
            @(negedge clk);
        end
        load_valid = 1'b0;
        load_en = 1'b0;
        rst = 1'b1;
        #1;
        check("async_rst_instr", 64'(fetch_instr), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_wc", 64'(word_count), 64'd0);
        check("post_rst_ovf", 64'(load_overflow), 64'd0);
        check("post_rst_done", 64'(load_done), 64'd0);
        bq = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_load(bq, 1'b0, 32'h0);
        check("rst_reload_wc", 64'(word_count), 64'd1);
        fetch_lit("rst_reload", 32'h0, 32'h4433_2211, 1'b0);

        // Reload from RUN: fetch at entry uses old data, stale word 1 faults.
        bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        do_load(bq, 1'b0, 32'h0);
        fetch_lit("old_w1", 32'h4, 32'h0807_0605, 1'b0);
        bq = '{8'h55, 8'h66, 8'h77, 8'h88};
        do_load(bq, 1'b1, 32'h0403_0201);
        check("reload_wc", 64'(word_count), 64'd1);
        fetch_lit("stale_w1", 32'h4, 32'h0, 1'b1);
        fetch_lit("new_w0", 32'h0, 32'h8877_6655, 1'b0);

        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/prog_mem_loader.md
Name: prog_mem_loader

Overview:
- Parametrised, loadable program memory that replaces the fixed 16-word instruction ROM.
- A byte-serial load port fills memory at run time. A fetch port then returns instructions with a fixed 1-cycle latency, bounds checking and alignment checking.
- Sits between the external program loader (UART/boot streamer) and the CPU fetch stage.

Parameters:
- DATA_W, 32, instruction width in bits; must be 8, 16, 32 or 64. BYTES = DATA_W/8; OFF_W = clog2(BYTES).
- ADDR_W, 4, word-address width; DEPTH = 2**ADDR_W words.
- NOP_WORD, 32'h00000000, value returned on faulting fetches; truncated or zero-extended to DATA_W.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- load_en  in  1  level; high requests LOAD mode.
- load_valid  in  1  load_byte is valid this cycle.
- load_byte  in  8  program byte, little-endian within a word.
- load_done  out  1  high while in RUN state.
- load_overflow  out  1  sticky: a byte was dropped because memory was full.
- word_count  out  ADDR_W+1  number of words written since the last load start.
- fetch_req  in  1  fetch request this cycle.
- fetch_addr  in  32  byte address of the fetch.
- fetch_valid  out  1  response strobe, exactly 1 cycle after fetch_req.
- fetch_instr  out  DATA_W  fetched instruction.
- fetch_fault  out  1  qualifies fetch_valid: misaligned, out-of-range or not in RUN.

Behaviour:
- Reset (asynchronous, any time):
  - State returns to IDLE.
  - All outputs go to 0; fetch_instr goes to 0.
  - Byte index, write pointer, word_count and the partial-word assembly register are cleared.
  - Memory array contents are not reset.
  - A reset mid-load discards the partial word.
- States: IDLE, LOAD, FLUSH, RUN.
  - IDLE -> LOAD when load_en=1.
  - LOAD -> FLUSH when load_en=0.
  - FLUSH -> RUN after 1 cycle.
  - RUN -> LOAD when load_en=1.
- Entering LOAD (from IDLE or RUN): word_count, write pointer, byte index and load_overflow are cleared in that same cycle.
- LOAD, per load_valid byte:
  - The byte goes into lane byte_idx of the assembly register, and byte_idx increments.
  - When byte_idx == BYTES-1, the completed word (including the current byte) is written to mem[wr_ptr]. wr_ptr and word_count increment and byte_idx wraps to 0.
  - If word_count == DEPTH, the byte is dropped and load_overflow is set. It stays set until the next LOAD entry or reset.
- FLUSH:
  - If byte_idx != 0 and word_count < DEPTH, the partial word is written with its unfilled upper lanes zeroed, and word_count increments.
  - byte_idx is then cleared.
- load_done = 1 only in RUN.
- Fetch, registered with 1-cycle latency; back-to-back requests are supported, with one response per request:
  - word index = fetch_addr >> OFF_W.
  - Fault conditions:
    - fetch_addr[OFF_W-1:0] != 0 (misaligned),
    - word index >= word_count (includes any address bits above ADDR_W+OFF_W set),
    - state != RUN.
  - On fault: fetch_valid=1, fetch_fault=1, fetch_instr=NOP_WORD.
  - Otherwise: fetch_valid=1, fetch_fault=0, fetch_instr=mem[index].
  - With no request: fetch_valid=0, fetch_fault=0, and fetch_instr holds its last value.
- Simultaneous events:
  - fetch_req in the same cycle as RUN->LOAD: the fetch is answered from RUN-state data (the state at the request edge). The next fetch faults.
  - load_valid in the same cycle that load_en falls: the byte is not captured.
  - Write and fetch of the same word cannot overlap, because fetches only succeed in RUN.
- Arithmetic: word_count saturates at DEPTH; wr_ptr is ADDR_W+1 bits and never wraps.

Test Plan:
- Load 8 bytes 01 00 00 00 02 00 00 00, drop load_en, wait for load_done, fetch 0x0 then 0x4 back-to-back:
  - responses 0x00000001 then 0x00000002, no fault;
  - word_count = 2.
- Load 5 bytes AA BB CC DD EE, end load, fetch 0x4:
  - instr 0x000000EE, fault 0;
  - word_count = 2.
- After the 2-word load, fetch 0x8 (out of range), 0x2 (misaligned) and 0x1000:
  - each gives fetch_valid=1, fault=1, instr 0x00000000.
- Load 68 bytes into the 16-word default:
  - word_count = 16, load_overflow = 1;
  - fetch 0x3C returns word 15, built from bytes 60..63.
- Fetch while in IDLE → fault=1.
- Assert rst after 3 bytes of a load, then reload 4 bytes 11 22 33 44:
  - mem[0] = 0x44332211;
  - word_count = 1.
- Reload from RUN with 1 word:
  - word_count resets to 0 on LOAD entry;
  - after the new load, fetch 0x4 faults even though the old data is still present.
